// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Define ALU_ARB_FUSED_EN to add the two-pass saturated abs-diff opcode 'h31.
module alu_arbiter (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [5:0]  i_req0_ctrl,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [5:0]  i_req1_ctrl,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   output logic        o_resp0_valid,
   input  logic        i_resp0_ready,
   output logic [31:0] o_resp0_r,
   output logic [31:0] o_resp0_r2,
   output logic        o_resp0_z,
   output logic        o_resp1_valid,
   input  logic        i_resp1_ready,
   output logic [31:0] o_resp1_r,
   output logic [31:0] o_resp1_r2,
   output logic        o_resp1_z,
   output logic [5:0]  o_alu_ctrl,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   input  logic [31:0] i_alu_r,
   input  logic [31:0] i_alu_r2,
   input  logic        i_alu_z
);

`ifdef ALU_ARB_FUSED_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_EXEC2 = 2'd2, ST_HOLD = 2'd3} state_t;
   localparam logic [5:0] OP_FUSED   = 6'h31;
   localparam logic [5:0] OP_SATDIFF = 6'h30;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_HOLD = 2'd3} state_t;
`endif

   state_t      r_state;
   state_t      w_state_next;
   logic        r_last_grant;
   logic        r_owner;
   logic [5:0]  r_alu_ctrl;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic        r_resp0_valid, r_resp1_valid;
   logic [31:0] r_resp0_r, r_resp0_r2, r_resp1_r, r_resp1_r2;
   logic        r_resp0_z, r_resp1_z;
`ifdef ALU_ARB_FUSED_EN
   logic        r_fused;
   logic [31:0] r_temp;
`endif

   logic        w_grant0, w_grant1, w_issue, w_owner_ready, w_capture;
   logic [5:0]  w_sel_ctrl;
   logic [31:0] w_sel_a, w_sel_b;
   logic [31:0] w_cap_r, w_cap_r2;
   logic        w_cap_z;

   // On a tie the requester that was not served last wins.
   assign w_grant0   = i_req0_valid && (!i_req1_valid || r_last_grant);
   assign w_grant1   = i_req1_valid && (!i_req0_valid || !r_last_grant);
   assign w_issue    = (r_state == ST_IDLE) && !i_reset && (w_grant0 || w_grant1);
   assign w_sel_ctrl = w_grant1 ? i_req1_ctrl : i_req0_ctrl;
   assign w_sel_a    = w_grant1 ? i_req1_a    : i_req0_a;
   assign w_sel_b    = w_grant1 ? i_req1_b    : i_req0_b;
   assign w_owner_ready = r_owner ? i_resp1_ready : i_resp0_ready;

`ifdef ALU_ARB_FUSED_EN
   assign w_capture = ((r_state == ST_EXEC) && !r_fused) || (r_state == ST_EXEC2);
`else
   assign w_capture = (r_state == ST_EXEC);
`endif

   always_comb begin
      w_cap_r  = i_alu_r;
      w_cap_r2 = i_alu_r2;
      w_cap_z  = i_alu_z;
`ifdef ALU_ARB_FUSED_EN
      // Second pass: the two one-sided clamped differences are disjoint, so OR merges them.
      if (r_state == ST_EXEC2) begin
         w_cap_r  = r_temp | i_alu_r;
         w_cap_r2 = 32'd0;
         w_cap_z  = ((r_temp | i_alu_r) == 32'd0);
      end
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_issue) w_state_next = ST_EXEC;
`ifdef ALU_ARB_FUSED_EN
         ST_EXEC:  w_state_next = r_fused ? ST_EXEC2 : ST_HOLD;
         ST_EXEC2: w_state_next = ST_HOLD;
`else
         ST_EXEC:  w_state_next = ST_HOLD;
`endif
         ST_HOLD: if (w_owner_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_req0_ready = (r_state == ST_IDLE) && !i_reset && w_grant0;
      o_req1_ready = (r_state == ST_IDLE) && !i_reset && w_grant1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_last_grant  <= 1'b1;
         r_owner       <= 1'b0;
         r_alu_ctrl    <= 6'd0;
         r_alu_a       <= 32'd0;
         r_alu_b       <= 32'd0;
         r_resp0_valid <= 1'b0;
         r_resp0_r     <= 32'd0;
         r_resp0_r2    <= 32'd0;
         r_resp0_z     <= 1'b0;
         r_resp1_valid <= 1'b0;
         r_resp1_r     <= 32'd0;
         r_resp1_r2    <= 32'd0;
         r_resp1_z     <= 1'b0;
`ifdef ALU_ARB_FUSED_EN
         r_fused       <= 1'b0;
         r_temp        <= 32'd0;
`endif
      end else begin
         if (w_issue) begin
            r_owner    <= w_grant1;
            r_alu_ctrl <= w_sel_ctrl;
            r_alu_a    <= w_sel_a;
            r_alu_b    <= w_sel_b;
`ifdef ALU_ARB_FUSED_EN
            r_fused    <= (w_sel_ctrl == OP_FUSED);
            if (w_sel_ctrl == OP_FUSED) r_alu_ctrl <= OP_SATDIFF;
`endif
         end
`ifdef ALU_ARB_FUSED_EN
         if ((r_state == ST_EXEC) && r_fused) begin
            r_temp  <= i_alu_r;
            r_alu_a <= r_alu_b;
            r_alu_b <= r_alu_a;
         end
`endif
         if (w_capture) begin
            if (r_owner) begin
               r_resp1_valid <= 1'b1;
               r_resp1_r     <= w_cap_r;
               r_resp1_r2    <= w_cap_r2;
               r_resp1_z     <= w_cap_z;
            end else begin
               r_resp0_valid <= 1'b1;
               r_resp0_r     <= w_cap_r;
               r_resp0_r2    <= w_cap_r2;
               r_resp0_z     <= w_cap_z;
            end
         end
         if ((r_state == ST_HOLD) && w_owner_ready) begin
            if (r_owner) r_resp1_valid <= 1'b0;
            else         r_resp0_valid <= 1'b0;
            r_last_grant <= r_owner;
         end
      end
   end

   assign o_alu_ctrl    = r_alu_ctrl;
   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_resp0_valid = r_resp0_valid;
   assign o_resp0_r     = r_resp0_r;
   assign o_resp0_r2    = r_resp0_r2;
   assign o_resp0_z     = r_resp0_z;
   assign o_resp1_valid = r_resp1_valid;
   assign o_resp1_r     = r_resp1_r;
   assign o_resp1_r2    = r_resp1_r2;
   assign o_resp1_z     = r_resp1_z;

endmodule
